// File: rtl/eq_pkg.sv
// Shared types and sizing for the equality-comparator sweep driver.
package eq_pkg;

    localparam int NUM_PAIRS = 256;
    localparam int OPERAND_W = 4;
    localparam int INDEX_W   = 2 * OPERAND_W;
    localparam int COUNT_W   = 9;

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_PAIRS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_SETTLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/eq_expect.sv
// Golden reference: what a correct 4-bit equality comparator should report.
module eq_expect
    import eq_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 expected
);

    // Pure combinational equality of the two operands.
    assign expected = (a == b);

endmodule

// File: rtl/eq_sweep_driver.sv
// Drives every {a,b} operand pair into an external 4-bit equality comparator
// through a shared test bus, checks its answer, and reports the error tally.
module eq_sweep_driver
    import eq_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 result_in,
    output logic [OPERAND_W-1:0] test,
    output logic [1:0]           pushbutton,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [COUNT_W-1:0]   err_count,
    output logic [OPERAND_W-1:0] fail_a,
    output logic [OPERAND_W-1:0] fail_b
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t               state;
    logic [INDEX_W-1:0]   index;
    logic [3:0]           settle_cnt;

    logic [OPERAND_W-1:0] op_a;
    logic [OPERAND_W-1:0] op_b;
    logic [INDEX_W-1:0]   next_index;
    logic                 expected;
    logic                 mismatch;

    // Split the pair index into its operands; a is the high nibble.
    assign op_a       = index[INDEX_W-1:OPERAND_W];
    assign op_b       = index[OPERAND_W-1:0];
    assign next_index = index + INDEX_W'(1);
    assign mismatch   = (result_in != expected);

    eq_expect u_expect (
        .a        (op_a),
        .b        (op_b),
        .expected (expected)
    );

    // Sweep sequencer: state, pair index, settle timer, strobes and error log.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            index      <= '0;
            settle_cnt <= '0;
            test       <= '0;
            pushbutton <= 2'b00;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, so ordering inside this block is free.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        index      <= '0;
                        err_count  <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        test       <= '0;
                        pushbutton <= 2'b01;
                        state      <= ST_LOAD_A;
                    end
                end

                ST_LOAD_A: begin
                    test       <= op_b;
                    pushbutton <= 2'b10;
                    state      <= ST_LOAD_B;
                end

                ST_LOAD_B: begin
                    pushbutton <= 2'b00;
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        if (mismatch) begin
                            err_count <= err_count + COUNT_W'(1);
                            if (err_count == '0) begin
                                fail_a <= op_a;
                                fail_b <= op_b;
                            end
                        end
                        if (index == LAST_INDEX) begin
                            state <= ST_DONE;
                        end else begin
                            index      <= next_index;
                            test       <= next_index[INDEX_W-1:OPERAND_W];
                            pushbutton <= 2'b01;
                            state      <= ST_LOAD_A;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                default: begin
                    pushbutton <= 2'b00;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decoded straight from the state register.
    assign busy = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_SETTLE);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_eq_sweep_driver.sv
// Directed bench for eq_sweep_driver with a behavioural comparator model.
module tb_eq_sweep_driver;

    logic       clk;
    logic       rst_n;
    logic       start1, start3;
    logic       res1, res3;

    logic [3:0] test1, test3;
    logic [1:0] pb1, pb3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [8:0] err1, err3;
    logic [3:0] fa1, fb1, fa3, fb3;

    int         errors = 0;
    int         checks = 0;
    int         mode   = 0;     // 0 good comparator, 1 stuck at 1, 2 stuck at 0
    bit         sel3   = 0;

    // Comparator models: operand registers loaded by the strobes.
    logic [3:0] c1a, c1b, c3a, c3b;
    logic       r1, r2;

    eq_sweep_driver #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .result_in(res1),
        .test(test1), .pushbutton(pb1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1)
    );

    eq_sweep_driver #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .result_in(res3),
        .test(test3), .pushbutton(pb3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .fail_a(fa3), .fail_b(fb3)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Comparator under test for each driver; dut3's answer lags two cycles.
    always @(posedge clk) begin
        if (pb1[0]) c1a <= test1;
        if (pb1[1]) c1b <= test1;
        if (pb3[0]) c3a <= test3;
        if (pb3[1]) c3b <= test3;
        r1 <= (c3a == c3b);
        r2 <= r1;
    end

    assign res1 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (c1a == c1b);
    assign res3 = r2;

    wire [1:0] s_pb   = sel3 ? pb3 : pb1;
    wire       s_done = sel3 ? done3 : done1;

    // Start a sweep; count edges from entering LOAD_A until done is seen.
    task automatic do_sweep(input bit use3, input int restart_at,
                            output int cycles, output bit pb_ok, output bit timed_out);
        sel3 = use3;
        @(posedge clk); #1;
        if (use3) start3 = 1; else start1 = 1;
        @(posedge clk); #1;
        start1 = 0; start3 = 0;
        cycles = 0; pb_ok = (s_pb != 2'b11); timed_out = 1;
        for (int i = 0; i < 3000; i++) begin
            if (cycles == restart_at) begin
                if (use3) start3 = 1; else start1 = 1;
            end
            @(posedge clk); #1;
            cycles++;
            start1 = 0; start3 = 0;
            if (s_pb == 2'b11) pb_ok = 0;
            if (s_done) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start1 = 0; start3 = 0;
        #1;
        checks++;
        if ({test1, pb1, busy1, done1, pass1, err1, fa1, fb1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {test1, pb1, busy1, done1, pass1, err1, fa1, fb1});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || pb1 !== 2'b00) begin
            errors++;
            $display("FAIL no_autostart: busy=%b done=%b pb=%b required 0 0 00",
                     busy1, done1, pb1);
        end
    endtask

    task automatic test_good_sweep();
        int cycles; bit ok, to;
        mode = 0;
        sel3 = 0;
        @(posedge clk); #1 start1 = 1;
        @(posedge clk); #1 start1 = 0;
        checks++;
        if (busy1 !== 1'b1 || pb1 !== 2'b01 || test1 !== 4'h0) begin
            errors++;
            $display("FAIL load_a: busy=%b pb=%b test=%h required 1 01 0", busy1, pb1, test1);
        end
        @(posedge clk); #1;
        checks++;
        if (pb1 !== 2'b10 || test1 !== 4'h0) begin
            errors++;
            $display("FAIL load_b: pb=%b test=%h required 10 0", pb1, test1);
        end
        @(posedge clk); #1;
        checks++;
        if (pb1 !== 2'b00 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL settle: pb=%b busy=%b required 00 1", pb1, busy1);
        end
        @(posedge clk); #1;
        checks++;
        if (pb1 !== 2'b01 || test1 !== 4'h0) begin
            errors++;
            $display("FAIL second_pair: pb=%b test=%h required 01 0", pb1, test1);
        end
        // let this sweep finish, then run a timed one from DONE
        for (int i = 0; i < 1000 && !done1; i++) @(posedge clk);
        do_sweep(0, -1, cycles, ok, to);
        checks++;
        if (to || cycles != 768) begin
            errors++;
            $display("FAIL good_cycles: got %0d (timeout=%0d) required 768", cycles, to);
        end
        checks++;
        if (pass1 !== 1'b1 || err1 !== 9'd0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL good_result: pass=%b err=%0d busy=%b required 1 0 0", pass1, err1, busy1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL good_pb_exclusive: both strobes seen high");
        end
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1) begin
            errors++;
            $display("FAIL done_held: done=%b pass=%b required 1 1", done1, pass1);
        end
    endtask

    task automatic test_stuck_high();
        int cycles; bit ok, to;
        mode = 1;
        do_sweep(0, -1, cycles, ok, to);
        checks++;
        if (to || err1 !== 9'd240 || fa1 !== 4'h0 || fb1 !== 4'h1 || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL stuck_high: err=%0d fa=%h fb=%h pass=%b to=%0d required 240 0 1 0 0",
                     err1, fa1, fb1, pass1, to);
        end
    endtask

    task automatic test_stuck_low();
        int cycles; bit ok, to;
        mode = 2;
        do_sweep(0, -1, cycles, ok, to);
        checks++;
        if (to || err1 !== 9'd16 || fa1 !== 4'h0 || fb1 !== 4'h0 || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL stuck_low: err=%0d fa=%h fb=%h pass=%b to=%0d required 16 0 0 0 0",
                     err1, fa1, fb1, pass1, to);
        end
        mode = 0;
    endtask

    task automatic test_start_ignored();
        int cycles; bit ok, to;
        mode = 0;
        do_sweep(0, 8'h37 * 3, cycles, ok, to);
        checks++;
        if (to || cycles != 768 || pass1 !== 1'b1 || err1 !== 9'd0) begin
            errors++;
            $display("FAIL start_ignored: cycles=%0d pass=%b err=%0d required 768 1 0",
                     cycles, pass1, err1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cycles; bit ok, to;
        mode = 2;   // accumulate errors so reset clearing is visible
        sel3 = 0;
        @(posedge clk); #1 start1 = 1;
        @(posedge clk); #1 start1 = 0;
        repeat (8'h80 * 3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        checks++;
        if ({test1, pb1, busy1, done1, pass1, err1, fa1, fb1} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h required 0",
                     {test1, pb1, busy1, done1, pass1, err1, fa1, fb1});
        end
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy1 !== 1'b0 || pb1 !== 2'b00 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle%0d: busy=%b pb=%b done=%b required 0 00 0",
                         i, busy1, pb1, done1);
            end
        end
        mode = 0;
        do_sweep(0, -1, cycles, ok, to);
        checks++;
        if (to || cycles != 768 || pass1 !== 1'b1 || err1 !== 9'd0) begin
            errors++;
            $display("FAIL midreset_resweep: cycles=%0d pass=%b err=%0d required 768 1 0",
                     cycles, pass1, err1);
        end
    endtask

    task automatic test_settle3();
        int cycles; bit ok, to;
        do_sweep(1, -1, cycles, ok, to);
        checks++;
        if (to || cycles != 1280) begin
            errors++;
            $display("FAIL settle3_cycles: got %0d (timeout=%0d) required 1280", cycles, to);
        end
        checks++;
        if (pass3 !== 1'b1 || err3 !== 9'd0) begin
            errors++;
            $display("FAIL settle3_result: pass=%b err=%0d required 1 0", pass3, err3);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL settle3_pb_exclusive: both strobes seen high");
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_stuck_high();
        test_stuck_low();
        test_start_ignored();
        test_reset_mid_sweep();
        test_settle3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
